alarm_trigger: RTL and testbench

//   Read side of the alarm-time registers: compares running clock time against the

---
 rtl/alarm_trigger_pkg.sv | 16 +
 rtl/alarm_trigger_if.sv | 31 +++
 rtl/alarm_trigger_match.sv | 34 +++
 rtl/alarm_trigger.sv | 146 ++++++++++++++
 tb/tb_alarm_trigger.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_trigger_pkg.sv
// Shared types and constants for the alarm trigger block.
// State encodings are fixed so the snooze and non-snooze builds agree.
package alarm_trigger_pkg;

  localparam int         CNT_W    = 10;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_trigger_if.sv
// Bundle of the clock-time, alarm-register, key and buzzer signals
// around alarm_trigger. master = surrounding clock top, slave = alarm_trigger.
interface alarm_trigger_if;

  logic       en;
  logic       sec_tick;
  logic [7:0] cur_hour;
  logic [7:0] cur_minute;
  logic [7:0] cur_second;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_minute;
  logic       alarm_on;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;

  modport master (
    output en, sec_tick, cur_hour, cur_minute, cur_second,
           alarm_hour, alarm_minute, alarm_on, stop, snooze,
    input  buzzer, ringing, snoozing
  );

  modport slave (
    input  en, sec_tick, cur_hour, cur_minute, cur_second,
           alarm_hour, alarm_minute, alarm_on, stop, snooze,
    output buzzer, ringing, snoozing
  );

endinterface

// File: rtl/alarm_trigger_match.sv
// alarm_match: BCD compare of running time against the alarm registers.
// Produces a single-cycle fire on the rising edge of the match condition,
// so a time that sits on hh:mm:00 for many cycles fires only once.
module alarm_match
  import alarm_trigger_pkg::*;
(
  input  logic       clk,
  input  logic       cr,
  input  logic       i_alarm_on,
  input  logic [7:0] i_cur_hour,
  input  logic [7:0] i_cur_minute,
  input  logic [7:0] i_cur_second,
  input  logic [7:0] i_alarm_hour,
  input  logic [7:0] i_alarm_minute,
  output logic       o_fire
);

  logic w_match;
  logic r_match_q;

  assign w_match = i_alarm_on
                 && (i_cur_hour   == i_alarm_hour)
                 && (i_cur_minute == i_alarm_minute)
                 && (i_cur_second == BCD_ZERO);

  // Track previous match every cycle (independent of enable) to suppress late fires.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) r_match_q <= 1'b0;
    else     r_match_q <= w_match;
  end

  assign o_fire = w_match & ~r_match_q;

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm FSM (IDLE/RING/SNOOZE), ring/wait/snooze counters
// and registered buzzer outputs.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined;
// otherwise the snooze key is ignored and snoozing is tied low.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic            clk,
  input  logic            cr,
  alarm_trigger_if.slave  bus
);

  localparam cnt_t RING_LAST = cnt_t'(RING_SECS - 1);

  state_e r_state, w_state_nxt;
  cnt_t   r_ring_cnt, w_ring_cnt_nxt;
  logic   r_ringing, r_buzzer;
  logic   w_fire;

  alarm_match u_match (
    .clk            (clk),
    .cr             (cr),
    .i_alarm_on     (bus.alarm_on),
    .i_cur_hour     (bus.cur_hour),
    .i_cur_minute   (bus.cur_minute),
    .i_cur_second   (bus.cur_second),
    .i_alarm_hour   (bus.alarm_hour),
    .i_alarm_minute (bus.alarm_minute),
    .o_fire         (w_fire)
  );

`ifdef ALARM_SNOOZE_EN
  localparam cnt_t       SNOOZE_LAST = cnt_t'(SNOOZE_SECS - 1);
  localparam logic [1:0] MAX_SN      = 2'(MAX_SNOOZE);

  cnt_t       r_wait_cnt,   w_wait_cnt_nxt;
  logic [1:0] r_snooze_cnt, w_snooze_cnt_nxt;
  logic       r_snoozing;
`else
  // Snooze key and snooze parameters have no function in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{bus.snooze, cnt_t'(SNOOZE_SECS), 2'(MAX_SNOOZE)};
`endif

  // State and counter registers; en=0 freezes everything here.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      r_state      <= ST_IDLE;
      r_ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
      r_wait_cnt   <= '0;
      r_snooze_cnt <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
`ifdef ALARM_SNOOZE_EN
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
`endif
    end
  end

  // Next state: in RING, stop/disarm beats snooze, which beats timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_ring_cnt_nxt   = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_wait_cnt_nxt   = r_wait_cnt;
    w_snooze_cnt_nxt = r_snooze_cnt;
`endif
    if (bus.en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            w_state_nxt      = ST_RING;
            w_ring_cnt_nxt   = '0;
`ifdef ALARM_SNOOZE_EN
            w_snooze_cnt_nxt = '0;
`endif
          end
        end
        ST_RING: begin
          if (bus.stop || !bus.alarm_on) begin
            w_state_nxt = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze && (r_snooze_cnt < MAX_SN)) begin
            w_state_nxt      = ST_SNOOZE;
            w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
            w_wait_cnt_nxt   = '0;
`endif
          end else if (bus.sec_tick) begin
            if (r_ring_cnt == RING_LAST) w_state_nxt = ST_IDLE;
            else                         w_ring_cnt_nxt = r_ring_cnt + 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (bus.stop || !bus.alarm_on) begin
            w_state_nxt      = ST_IDLE;
            w_snooze_cnt_nxt = '0;
          end else if (bus.sec_tick) begin
            if (r_wait_cnt == SNOOZE_LAST) begin
              w_state_nxt    = ST_RING;
              w_ring_cnt_nxt = '0;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs follow the state one cycle later; buzzer pulses 1 s on / 1 s off.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      r_ringing <= 1'b0;
      r_buzzer  <= 1'b0;
    end else begin
      r_ringing <= (r_state == ST_RING);
      r_buzzer  <= bus.en && (r_state == ST_RING) && !r_ring_cnt[0];
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze indicator register.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) r_snoozing <= 1'b0;
    else     r_snoozing <= (r_state == ST_SNOOZE);
  end
  assign bus.snoozing = r_snoozing;
`else
  assign bus.snoozing = 1'b0;
`endif

  assign bus.ringing = r_ringing;
  assign bus.buzzer  = r_buzzer;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger. Snooze checks run only when
// ALARM_SNOOZE_EN is defined for the build.
module tb_alarm_trigger;

  logic clk = 1'b0;
  logic cr;
  int   n_pass = 0;
  int   n_tot  = 0;

  alarm_trigger_if bus();

  alarm_trigger #(.RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
    .clk (clk),
    .cr  (cr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hour   = h;
    bus.cur_minute = m;
    bus.cur_second = s;
  endtask

  task automatic sec();
    bus.sec_tick = 1'b1;
    step();
    bus.sec_tick = 1'b0;
    step();
  endtask

  // Walk hh:(mm):59 -> hh:mm:00 and wait out the 2-cycle output latency.
  task automatic trigger(input logic [7:0] h, input logic [7:0] m);
    set_time(h, m, 8'h59);
    step();
    set_time(h, m, 8'h00);
    steps(2);
  endtask

  task automatic press_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
  endtask

  initial begin
    cr = 1'b0;
    bus.en = 1'b1; bus.sec_tick = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
    bus.alarm_on = 1'b0; bus.alarm_hour = 8'h07; bus.alarm_minute = 8'h30;
    set_time(8'h07, 8'h29, 8'h59);
    steps(2);
    chk("rst_ringing",  bus.ringing,  1'b0);
    chk("rst_buzzer",   bus.buzzer,   1'b0);
    chk("rst_snoozing", bus.snoozing, 1'b0);

    // 1: 07:29:59 -> 07:30:00, outputs two clocks after fire
    cr = 1'b1;
    bus.alarm_on = 1'b1;
    step();
    chk("pre_fire", bus.ringing, 1'b0);
    set_time(8'h07, 8'h30, 8'h00);
    step();
    chk("lat1_ringing", bus.ringing, 1'b0);
    step();
    chk("lat2_ringing", bus.ringing, 1'b1);
    chk("lat2_buzzer",  bus.buzzer,  1'b1);

    // 2: untouched ring, buzzer toggles per second, timeout after tick 60
    for (int k = 1; k <= 59; k++) begin
      sec();
      chk("ring_hold", bus.ringing, 1'b1);
      chk("ring_buzz", bus.buzzer, (k % 2 == 0));
    end
    sec();
    chk("timeout_ringing", bus.ringing, 1'b0);
    chk("timeout_buzzer",  bus.buzzer,  1'b0);
    steps(3);
    chk("no_refire_00", bus.ringing, 1'b0);
    set_time(8'h07, 8'h30, 8'h30);
    steps(2);
    chk("no_refire_30", bus.ringing, 1'b0);

    // 3: stop and snooze in the same cycle -> IDLE
    trigger(8'h07, 8'h30);
    chk("t3_ringing", bus.ringing, 1'b1);
    bus.stop = 1'b1; bus.snooze = 1'b1;
    step();
    bus.stop = 1'b0; bus.snooze = 1'b0;
    step();
    chk("t3_stop_ringing",  bus.ringing,  1'b0);
    chk("t3_stop_buzzer",   bus.buzzer,   1'b0);
    chk("t3_stop_snoozing", bus.snoozing, 1'b0);

`ifdef ALARM_SNOOZE_EN
    // 4: snooze cycle, limit of three snoozes
    trigger(8'h07, 8'h30);
    for (int k = 0; k < 10; k++) sec();
    for (int n = 1; n <= 3; n++) begin
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      step();
      chk("sn_snoozing", bus.snoozing, 1'b1);
      chk("sn_ringing",  bus.ringing,  1'b0);
      chk("sn_buzzer",   bus.buzzer,   1'b0);
      for (int k = 0; k < 299; k++) sec();
      chk("sn_wait", bus.snoozing, 1'b1);
      sec();
      chk("sn_back_ringing", bus.ringing, 1'b1);
      chk("sn_back_buzzer",  bus.buzzer,  1'b1);
    end
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    step();
    chk("sn4_ringing",  bus.ringing,  1'b1);
    chk("sn4_snoozing", bus.snoozing, 1'b0);
    press_stop();
    chk("sn_stop", bus.ringing, 1'b0);
`endif

    // 5: async reset mid-ring, then disarm mid-ring
    trigger(8'h07, 8'h30);
    chk("t5_ringing", bus.ringing, 1'b1);
    set_time(8'h07, 8'h30, 8'h01);
    #2;
    cr = 1'b0;
    #1;
    chk("async_ringing", bus.ringing, 1'b0);
    chk("async_buzzer",  bus.buzzer,  1'b0);
    step();
    cr = 1'b1;
    steps(2);
    chk("post_rst_idle", bus.ringing, 1'b0);
    trigger(8'h07, 8'h30);
    chk("t5b_ringing", bus.ringing, 1'b1);
    bus.alarm_on = 1'b0;
    set_time(8'h07, 8'h30, 8'h01);
    steps(2);
    chk("disarm_ringing", bus.ringing, 1'b0);
    bus.alarm_on = 1'b1;

    // en=0 during ring: buzzer forced off, counter frozen
    trigger(8'h07, 8'h30);
    bus.en = 1'b0;
    steps(2);
    chk("en0_ringing", bus.ringing, 1'b1);
    chk("en0_buzzer",  bus.buzzer,  1'b0);
    sec();
    bus.en = 1'b1;
    steps(2);
    chk("en1_buzzer_held", bus.buzzer, 1'b1);
    press_stop();
    chk("en_stop", bus.ringing, 1'b0);

    // 6: en=0 across the match, re-enabled at 07:30:05 -> no late fire
    set_time(8'h07, 8'h29, 8'h59);
    step();
    bus.en = 1'b0;
    set_time(8'h07, 8'h30, 8'h00);
    steps(4);
    set_time(8'h07, 8'h30, 8'h05);
    step();
    bus.en = 1'b1;
    steps(3);
    chk("en_late_ringing", bus.ringing, 1'b0);
    chk("en_late_buzzer",  bus.buzzer,  1'b0);

    // Boundary time 23:59 and near misses
    bus.alarm_hour = 8'h23; bus.alarm_minute = 8'h59;
    trigger(8'h22, 8'h59);
    chk("hour_miss", bus.ringing, 1'b0);
    trigger(8'h23, 8'h58);
    chk("min_miss", bus.ringing, 1'b0);
    bus.alarm_on = 1'b0;
    trigger(8'h23, 8'h59);
    chk("unarmed", bus.ringing, 1'b0);
    bus.alarm_on = 1'b1;
    trigger(8'h23, 8'h59);
    chk("t6_2359_ringing", bus.ringing, 1'b1);
    chk("t6_2359_buzzer",  bus.buzzer,  1'b1);
    press_stop();
    chk("t6_stop", bus.ringing, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
